// File: rtl/mult_rr_sched_if.sv
// Bundle of requester, multiplier and result signals shared by mult_rr_sched
// and whatever drives it. The scheduler uses the slave modport.
interface mult_rr_sched_if #(
    parameter int width = 8,
    parameter int nreq  = 4
);
    logic [nreq-1:0]       req_valid;
    logic [nreq*width-1:0] req_a;
    logic [nreq*width-1:0] req_b;
    logic [nreq-1:0]       req_ready;
    logic [width-1:0]      mul_a;
    logic [width-1:0]      mul_b;
    logic [2*width-1:0]    mul_y;
    logic [nreq-1:0]       rsp_valid;
    logic [2*width-1:0]    rsp_y;
    logic                  busy;
    logic [15:0]           issued;

    modport slave (
        input  req_valid, req_a, req_b, mul_y,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_y, busy, issued
    );

    modport master (
        output req_valid, req_a, req_b, mul_y,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_y, busy, issued
    );
endinterface

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among nreq
// requesters. One operand pair is accepted per cycle; a tag pipeline follows
// each operation through the multiplier so the product is returned to the
// right requester with a one-hot strobe.
module mult_rr_sched #(
    parameter int width   = 8,
    parameter int nreq    = 4,
    parameter int mul_lat = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_rr_sched_if.slave  bus
);
    localparam int IDW = (nreq > 1) ? $clog2(nreq) : 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(nreq - 1);

    // Decode a requester index into a one-hot strobe vector.
    function automatic logic [nreq-1:0] onehot(input logic [IDW-1:0] id);
        logic [nreq-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Arbitration / operand selection
    logic [IDW-1:0]   last_q;
    logic             found_s;
    logic [IDW-1:0]   grant_id_s;
    logic [IDW-1:0]   cand_s;
    logic [nreq-1:0]  req_ready_s;
    logic [width-1:0] op_a_s;
    logic [width-1:0] op_b_s;

    // Multiplier drive, tag pipeline and result registers
    logic [width-1:0]   mul_a_q;
    logic [width-1:0]   mul_b_q;
    logic [mul_lat:0]   tag_v_q;
    logic [IDW-1:0]     tag_id_q [mul_lat+1];
    logic [nreq-1:0]    rsp_valid_q;
    logic [2*width-1:0] rsp_y_q;
    logic               busy_q;
    logic [15:0]        issued_q;
    logic               busy_d;

    // Scan requesters from the one after the last grant, wrapping; first valid wins.
    always_comb begin
        found_s    = 1'b0;
        grant_id_s = '0;
        cand_s     = '0;
        for (int k = 1; k <= nreq; k++) begin
            cand_s = IDW'((int'(last_q) + k) % nreq);
            if (!found_s && bus.req_valid[cand_s]) begin
                found_s    = 1'b1;
                grant_id_s = cand_s;
            end else begin
                grant_id_s = grant_id_s;
            end
        end
    end

    // Build the one-hot grant and pick the granted requester's operands.
    always_comb begin
        req_ready_s = '0;
        op_a_s      = '0;
        op_b_s      = '0;
        for (int k = 0; k < nreq; k++) begin
            if (found_s && (grant_id_s == IDW'(k))) begin
                req_ready_s[k] = 1'b1;
                op_a_s         = bus.req_a[k*width +: width];
                op_b_s         = bus.req_b[k*width +: width];
            end else begin
                req_ready_s[k] = 1'b0;
            end
        end
    end

    // Busy next state: something enters the tag pipeline, or some stage
    // (including the one about to become a result strobe) is still occupied.
    always_comb begin
        busy_d = found_s | (|tag_v_q);
    end

    // Operand registers, RR pointer, tag shift, result capture and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            last_q      <= LAST_RST;
            tag_v_q     <= '0;
            for (int s = 0; s <= mul_lat; s++) begin
                tag_id_q[s] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            busy_q      <= 1'b0;
            issued_q    <= 16'd0;
        end else begin
            if (found_s) begin
                mul_a_q  <= op_a_s;
                mul_b_q  <= op_b_s;
                last_q   <= grant_id_s;
                issued_q <= issued_q + 16'd1;
            end
            tag_v_q     <= {tag_v_q[mul_lat-1:0], found_s};
            tag_id_q[0] <= grant_id_s;
            for (int s = 1; s <= mul_lat; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            // The last tag stage lines up with mul_y from the multiplier.
            if (tag_v_q[mul_lat]) begin
                rsp_valid_q <= onehot(tag_id_q[mul_lat]);
                rsp_y_q     <= bus.mul_y;
            end else begin
                rsp_valid_q <= '0;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.busy      = busy_q;
    assign bus.issued    = issued_q;
endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed bench for mult_rr_sched with a behavioural 2-stage multiplier.
module tb_mult_rr_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mult_rr_sched_if #(.width(8), .nreq(4)) bus ();

    mult_rr_sched #(.width(8), .nreq(4), .mul_lat(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Attached multiplier: input registers then output register, no reset.
    logic [7:0]  ma_q;
    logic [7:0]  mb_q;
    logic [15:0] my_q;
    always @(posedge clk) begin
        ma_q <= bus.mul_a;
        mb_q <= bus.mul_b;
        my_q <= 16'(ma_q) * 16'(mb_q);
    end
    assign bus.mul_y = my_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        bus.req_valid = 4'b0000;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [3:0] exp_oh;
    int         acc_t [4] = '{0, 1, 3, 9};
    int         k;
    int         r;
    logic [7:0] last_a;
    logic [7:0] last_b;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;

        // ---- single op + reset state
        do_reset();
        check_eq("rst_mul_a", bus.mul_a, 8'd0);
        check_eq("rst_mul_b", bus.mul_b, 8'd0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 4'd0);
        check_eq("rst_rsp_y", bus.rsp_y, 16'd0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_issued", bus.issued, 16'd0);
        set_req(2, 8'd13, 8'd11);
        bus.req_valid = 4'b0100;
        #1 check_eq("single_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        #1 check_eq("single_ready_off", bus.req_ready, 4'b0000);
        check_eq("single_issued", bus.issued, 16'd1);
        check_eq("single_busy0", bus.busy, 1'b1);
        check_eq("single_mul_a", bus.mul_a, 8'd13);
        check_eq("single_mul_b", bus.mul_b, 8'd11);
        tick();
        check_eq("single_rv_e1", bus.rsp_valid, 4'b0000);
        tick();
        check_eq("single_rv_e2", bus.rsp_valid, 4'b0000);
        tick();
        check_eq("single_rv_e3", bus.rsp_valid, 4'b0100);
        check_eq("single_y", bus.rsp_y, 16'd143);
        check_eq("single_busy3", bus.busy, 1'b1);
        tick();
        check_eq("single_rv_e4", bus.rsp_valid, 4'b0000);
        check_eq("single_busy4", bus.busy, 1'b0);
        check_eq("single_y_hold", bus.rsp_y, 16'd143);

        // ---- full contention
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'hFF);
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                bus.req_valid = 4'b1111;
                exp_oh = 4'b0001 << (c % 4);
            end else begin
                bus.req_valid = 4'b0000;
                exp_oh = 4'b0000;
            end
            #1 check_eq("cont_ready", bus.req_ready, exp_oh);
            tick();
            check_eq("cont_issued", bus.issued, (c < 8) ? c + 1 : 8);
            if (c >= 3) begin
                r = (c - 3) % 4;
                exp_oh = 4'b0001 << r;
                check_eq("cont_rsp_valid", bus.rsp_valid, exp_oh);
                check_eq("cont_rsp_y", bus.rsp_y, (r + 1) * 255);
            end else begin
                check_eq("cont_rsp_valid_early", bus.rsp_valid, 4'b0000);
            end
        end

        // ---- max operands, then zero product
        do_reset();
        set_req(0, 8'hFF, 8'hFF);
        bus.req_valid = 4'b0001;
        #1 check_eq("max_ready0", bus.req_ready, 4'b0001);
        tick();
        set_req(0, 8'h00, 8'hFF);
        #1 check_eq("max_ready1", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0000;
        check_eq("zero_mul_a", bus.mul_a, 8'h00);
        check_eq("zero_mul_b", bus.mul_b, 8'hFF);
        tick();
        tick();
        check_eq("max_rv", bus.rsp_valid, 4'b0001);
        check_eq("max_y", bus.rsp_y, 16'hFE01);
        tick();
        check_eq("zero_rv", bus.rsp_valid, 4'b0001);
        check_eq("zero_y", bus.rsp_y, 16'h0000);
        tick();
        check_eq("zero_rv_off", bus.rsp_valid, 4'b0000);

        // ---- fairness skip
        do_reset();
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            exp_oh = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            #1 check_eq("fair_ready", bus.req_ready, exp_oh);
            tick();
        end
        bus.req_valid = 4'b1011;
        #1 check_eq("fair_req0_first", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b1010;
        #1 check_eq("fair_then_req1", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0000;

        // ---- reset mid-flight
        do_reset();
        set_req(0, 8'd2, 8'd3);
        set_req(1, 8'd4, 8'd5);
        set_req(2, 8'd6, 8'd7);
        bus.req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            exp_oh = 4'b0001 << c;
            #1 check_eq("mid_ready", bus.req_ready, exp_oh);
            tick();
        end
        bus.req_valid = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_mul_a", bus.mul_a, 8'd0);
        check_eq("mid_rst_mul_b", bus.mul_b, 8'd0);
        check_eq("mid_rst_rv", bus.rsp_valid, 4'd0);
        check_eq("mid_rst_y", bus.rsp_y, 16'd0);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_issued", bus.issued, 16'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq("mid_no_rsp", bus.rsp_valid, 4'b0000);
            check_eq("mid_no_busy", bus.busy, 1'b0);
        end
        set_req(3, 8'd7, 8'd9);
        bus.req_valid = 4'b1000;
        #1 check_eq("mid_next_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check_eq("mid_next_rv_e2", bus.rsp_valid, 4'b0000);
        tick();
        check_eq("mid_next_rv", bus.rsp_valid, 4'b1000);
        check_eq("mid_next_y", bus.rsp_y, 16'd63);

        // ---- idle gaps 0,1,5 between accepts on requester 1
        do_reset();
        last_a = 8'd0;
        last_b = 8'd0;
        for (int t = 0; t < 14; t++) begin
            k = -1;
            for (int j = 0; j < 4; j++) if (acc_t[j] == t) k = j;
            if (k >= 0) begin
                set_req(1, 8'(k + 2), 8'(k + 3));
                last_a = 8'(k + 2);
                last_b = 8'(k + 3);
                bus.req_valid = 4'b0010;
                exp_oh = 4'b0010;
            end else begin
                bus.req_valid = 4'b0000;
                exp_oh = 4'b0000;
            end
            #1 check_eq("gap_ready", bus.req_ready, exp_oh);
            tick();
            check_eq("gap_mul_a", bus.mul_a, last_a);
            check_eq("gap_mul_b", bus.mul_b, last_b);
            r = -1;
            for (int j = 0; j < 4; j++) if (acc_t[j] + 3 == t) r = j;
            exp_oh = (r >= 0) ? 4'b0010 : 4'b0000;
            check_eq("gap_rv", bus.rsp_valid, exp_oh);
            if (r >= 0) check_eq("gap_y", bus.rsp_y, (r + 2) * (r + 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_rr_sched.md
Name: mult_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined width x width multiplier among nreq requesters.
- The multiplier has a 2-cycle register latency (input regs, then output reg) and no reset.
- Each requester presents operands with a valid/ready handshake. The block accepts at most one per cycle, drives the multiplier from its own operand registers and tracks the requester ID through the pipeline.
- It returns each product on a shared result bus with a one-hot valid. It sits between the requester-side controllers and the multiplier instance.

Parameters:
- width, 8, operand width; product width is 2*width
- nreq, 4, number of requesters (2..8)
- mul_lat, 2, register latency of the attached multiplier (mul_a/mul_b sampled -> mul_y valid)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  nreq  bit i: requester i has operands pending
- req_a  in  nreq*width  requester i operand a at bits [i*width +: width]
- req_b  in  nreq*width  requester i operand b, same packing
- req_ready  out  nreq  one-hot grant; bit i high = requester i accepted this cycle
- mul_a  out  width  registered operand a to multiplier
- mul_b  out  width  registered operand b to multiplier
- mul_y  in  2*width  multiplier product
- rsp_valid  out  nreq  one-hot, one-cycle strobe: product for requester i on rsp_y
- rsp_y  out  2*width  registered product
- busy  out  1  high while any accepted operation has not yet produced rsp_valid
- issued  out  16  wrapping count of accepted operations

Behaviour:
- Reset (async assert, sync release): mul_a=0, mul_b=0, rsp_valid=0, rsp_y=0, busy=0, issued=0.
  - Tag pipeline cleared; RR pointer last = nreq-1, so requester 0 has highest priority first.
  - Reset mid-operation drops all in-flight ops silently; no rsp_valid for them after release.
- Arbitration (combinational):
  - Scan requesters starting at (last+1) mod nreq, wrapping. The first with req_valid=1 gets req_ready=1.
  - req_ready is never high for a requester with req_valid=0. At most one bit is set.
  - req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- Handshake:
  - A transfer occurs on the rising edge where req_valid[i] & req_ready[i].
  - A requester keeps valid and operands stable until accepted; the block relies on this and does not check it.
  - Throughput is one accept per cycle; no stalls.
- On accept at edge E0:
  - mul_a/mul_b <= operands of granted requester; last <= i; issued <= issued+1.
  - Tag stage 0 <= {1, i}.
  - With no accept, mul_a/mul_b hold their value and tag stage 0 valid <= 0.
- Tag pipeline:
  - mul_lat+1 stages of {valid, id}, shifted every cycle.
  - The stage aligned with mul_y (after mul_lat edges) loads rsp_y <= mul_y at the next edge.
  - rsp_valid <= onehot(id) if that stage is valid, else 0.
- Latency:
  - Accept at E0 gives rsp_valid high during the cycle after edge E0+mul_lat+1 (4 edges for mul_lat=2).
  - rsp_valid stays high for exactly one cycle.
  - rsp_y holds its last value when rsp_valid=0.
- Result width:
  - rsp_y = unsigned full product, 2*width bits, no truncation.
  - (2^width-1)^2 must be exact.
- Ordering: results return in accept order. There is no response back-pressure; consumers must sample on rsp_valid.
- busy = OR of all tag-stage valid bits, plus the result-stage valid (rsp_valid non-zero).
- Simultaneous events:
  - Accept and result in the same cycle are independent.
  - All requesters valid yields strict rotation 0,1,2,3,0,...
- issued wraps from 16'hFFFF to 0.

Test Plan:
- Single op: reset, then req 2 valid with a=8'd13, b=8'd11.
  - Expect req_ready=4'b0100 for one cycle.
  - rsp_valid=4'b0100 and rsp_y=16'd143 exactly 4 edges after accept; busy falls the cycle after.
- Full contention: all 4 valid continuously, each with a=i+1, b=8'hFF.
  - Grants rotate 0,1,2,3,0 one per cycle.
  - Responses in the same order with y=255,510,765,1020; issued increments every cycle.
- Max operands: a=b=8'hFF.
  - rsp_y=16'hFE01.
  - Then a=0, b=8'hFF gives rsp_y=0 with rsp_valid still asserted.
- Fairness skip: only req 1 and req 3 valid, last=0.
  - Grants 1,3,1,3.
  - req 0 rising mid-stream (after a grant to 3) is granted next, before 1.
- Reset mid-flight: 3 ops accepted on consecutive cycles, rst_n low 1 cycle after the third accept.
  - All outputs 0 immediately (async).
  - No rsp_valid ever appears for those ops after release.
  - The next op returns correctly with 4-edge latency.
- Idle gaps: accepts separated by 0,1,5 idle cycles.
  - rsp_valid pulses are spaced identically.
  - mul_a/mul_b hold between accepts.
